// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared definitions for the writeback arbiter.
//   - default data/register-index widths and queue depth
//   - requester port indices (PORT_ALU / PORT_MEM)
//   - queue entry type {rd, data} at the default widths
package wb_arb_pkg;

  localparam int BIT_WIDTH_DEF  = 32;
  localparam int REG_WIDTH_DEF  = 4;
  localparam int FIFO_DEPTH_DEF = 2;

  localparam logic PORT_ALU = 1'b0;
  localparam logic PORT_MEM = 1'b1;

  typedef struct packed {
    logic [REG_WIDTH_DEF-1:0] rd;
    logic [BIT_WIDTH_DEF-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: requester handshakes plus register-file write port.
//   master : requester/testbench side (drives *_valid/*_reg/*_data)
//   slave  : arbiter side (drives *_ready, wb_*, pend_mask, conflict_cnt)
interface wb_arbiter_if #(
  parameter int BIT_WIDTH = wb_arb_pkg::BIT_WIDTH_DEF,
  parameter int REG_WIDTH = wb_arb_pkg::REG_WIDTH_DEF
);
  logic                       alu_valid;
  logic                       alu_ready;
  logic [REG_WIDTH-1:0]       alu_reg;
  logic [BIT_WIDTH-1:0]       alu_data;
  logic                       mem_valid;
  logic                       mem_ready;
  logic [REG_WIDTH-1:0]       mem_reg;
  logic [BIT_WIDTH-1:0]       mem_data;
  logic                       wb_en;
  logic [REG_WIDTH-1:0]       wb_reg;
  logic [BIT_WIDTH-1:0]       wb_data;
  logic [(1<<REG_WIDTH)-1:0]  pend_mask;
  logic [15:0]                conflict_cnt;

  modport master (
    output alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
    input  alu_ready, mem_ready, wb_en, wb_reg, wb_data, pend_mask, conflict_cnt
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
    output alu_ready, mem_ready, wb_en, wb_reg, wb_data, pend_mask, conflict_cnt
  );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: per-requester writeback queue.
//   clk, rst (sync, active-high), flush : clock / clear controls
//   push_i, push_reg_i, push_data_i     : enqueue (ignored when full)
//   pop_i                               : dequeue head (ignored when empty)
//   head_reg_o, head_data_o             : oldest entry
//   count_o                             : occupancy 0..DEPTH
//   ent_vld_o, ent_reg_o                : per-slot view for pending-register tracking
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int RW    = 4,
  parameter int DW    = 32,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push_i,
  input  logic [RW-1:0]            push_reg_i,
  input  logic [DW-1:0]            push_data_i,
  input  logic                     pop_i,
  output logic [RW-1:0]            head_reg_o,
  output logic [DW-1:0]            head_data_o,
  output logic [CW-1:0]            count_o,
  output logic [DEPTH-1:0]         ent_vld_o,
  output logic [DEPTH-1:0][RW-1:0] ent_reg_o
);
  logic [DEPTH-1:0][RW-1:0] reg_q;
  logic [DEPTH-1:0][DW-1:0] data_q;
  logic [DEPTH-1:0]         vld_q;
  logic [PW-1:0]            rd_q, wr_q;
  logic [CW-1:0]            cnt_q;
  logic                     do_push, do_pop;

  assign do_push = push_i && (cnt_q < CW'(DEPTH));
  assign do_pop  = pop_i  && (cnt_q != '0);

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Control state: cleared by reset and flush. A push and pop in the same
  // cycle never touch the same slot (count is strictly between 0 and DEPTH).
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        vld_q[wr_q] <= 1'b1;
        wr_q        <= wrap_inc(wr_q);
      end
      if (do_pop) begin
        vld_q[rd_q] <= 1'b0;
        rd_q        <= wrap_inc(rd_q);
      end
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Payload storage needs no reset; slot validity lives in vld_q.
  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) begin
      reg_q[wr_q]  <= push_reg_i;
      data_q[wr_q] <= push_data_i;
    end
  end

  assign head_reg_o  = reg_q[rd_q];
  assign head_data_o = data_q[rd_q];
  assign count_o     = cnt_q;
  assign ent_vld_o   = vld_q;
  assign ent_reg_o   = reg_q;
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU and MEM writebacks into one register-file write port.
//   clk   : clock, all state on posedge
//   rst   : synchronous active-high reset (overrides flush and handshakes)
//   flush : empties both queues, suppresses the next wb_en, drops same-cycle pushes
//   bus   : wb_arbiter_if.slave -- ALU/MEM valid/ready/reg/data in,
//           wb_en/wb_reg/wb_data, pend_mask, conflict_cnt out
// Build option: define WB_ARBITER_PERF_EN to build the saturating contention
// counter behind conflict_cnt; otherwise conflict_cnt is tied to zero.
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int BIT_WIDTH  = BIT_WIDTH_DEF,
  parameter int REG_WIDTH  = REG_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  wb_arbiter_if.slave  bus
);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int NREG = 1 << REG_WIDTH;

  logic [1:0]                                 push, pop, ne, rdy;
  logic [1:0][CW-1:0]                         cnt;
  logic [1:0][REG_WIDTH-1:0]                  push_reg, head_reg;
  logic [1:0][BIT_WIDTH-1:0]                  push_data, head_data;
  logic [1:0][FIFO_DEPTH-1:0]                 ent_vld;
  logic [1:0][FIFO_DEPTH-1:0][REG_WIDTH-1:0]  ent_reg;

  assign push_reg[PORT_ALU]  = bus.alu_reg;
  assign push_reg[PORT_MEM]  = bus.mem_reg;
  assign push_data[PORT_ALU] = bus.alu_data;
  assign push_data[PORT_MEM] = bus.mem_data;
  assign push[PORT_ALU]      = bus.alu_valid & rdy[PORT_ALU];
  assign push[PORT_MEM]      = bus.mem_valid & rdy[PORT_MEM];
  assign bus.alu_ready       = rdy[PORT_ALU];
  assign bus.mem_ready       = rdy[PORT_MEM];

  // Arbitration: a lone non-empty head wins; on contention the port not
  // granted last wins. last_q resets to MEM so ALU takes the first conflict.
  logic gnt_vld, gnt_port, last_q, last_d;

  always_comb begin
    gnt_vld = |ne;
    if (&ne) gnt_port = ~last_q;
    else     gnt_port = ne[PORT_MEM] ? PORT_MEM : PORT_ALU;
  end

  for (genvar p = 0; p < 2; p++) begin : g_q
    // ready depends only on occupancy, never on a same-cycle pop
    assign rdy[p] = cnt[p] < CW'(FIFO_DEPTH);
    assign ne[p]  = cnt[p] != '0;
    assign pop[p] = gnt_vld && (gnt_port == 1'(p));

    wb_fifo #(
      .DEPTH (FIFO_DEPTH),
      .RW    (REG_WIDTH),
      .DW    (BIT_WIDTH)
    ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .push_i      (push[p]),
      .push_reg_i  (push_reg[p]),
      .push_data_i (push_data[p]),
      .pop_i       (pop[p]),
      .head_reg_o  (head_reg[p]),
      .head_data_o (head_data[p]),
      .count_o     (cnt[p]),
      .ent_vld_o   (ent_vld[p]),
      .ent_reg_o   (ent_reg[p])
    );
  end

  // Writeback output register. wb_reg/wb_data hold when nothing is granted
  // or on flush; only wb_en is forced low.
  logic                 wb_en_q, wb_en_d;
  logic [REG_WIDTH-1:0] wb_reg_q, wb_reg_d;
  logic [BIT_WIDTH-1:0] wb_data_q, wb_data_d;

  always_comb begin
    wb_en_d   = 1'b0;
    wb_reg_d  = wb_reg_q;
    wb_data_d = wb_data_q;
    last_d    = last_q;
    if (!flush && gnt_vld) begin
      wb_en_d   = 1'b1;
      wb_reg_d  = head_reg[gnt_port];
      wb_data_d = head_data[gnt_port];
      last_d    = gnt_port;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en_q   <= 1'b0;
      wb_reg_q  <= '0;
      wb_data_q <= '0;
      last_q    <= PORT_MEM;
    end else begin
      wb_en_q   <= wb_en_d;
      wb_reg_q  <= wb_reg_d;
      wb_data_q <= wb_data_d;
      last_q    <= last_d;
    end
  end

  assign bus.wb_en   = wb_en_q;
  assign bus.wb_reg  = wb_reg_q;
  assign bus.wb_data = wb_data_q;

  // Registers still waiting in either queue; the output register is excluded.
  logic [NREG-1:0] pend;
  always_comb begin
    pend = '0;
    for (int p = 0; p < 2; p++)
      for (int e = 0; e < FIFO_DEPTH; e++)
        if (ent_vld[p][e]) pend[ent_reg[p][e]] = 1'b1;
  end
  assign bus.pend_mask = pend;

`ifdef WB_ARBITER_PERF_EN
  // Counts posedges with both queues occupied; only rst clears it.
  logic [15:0] conf_q;
  always_ff @(posedge clk) begin
    if (rst)                              conf_q <= '0;
    else if (&ne && conf_q != 16'hFFFF)   conf_q <= conf_q + 16'd1;
  end
  assign bus.conflict_cnt = conf_q;
`else
  assign bus.conflict_cnt = '0;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
  import wb_arb_pkg::*;

  localparam int BW = 32, RW = 4, D = 2;
`ifdef WB_ARBITER_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, flush;
  always #5 clk = ~clk;

  wb_arbiter_if #(.BIT_WIDTH(BW), .REG_WIDTH(RW)) bus ();
  wb_arbiter #(.BIT_WIDTH(BW), .REG_WIDTH(RW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus)
  );

  int n_tests, n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: queues + round-robin rule ----------------
  wb_entry_t aq[$], mq[$];
  bit        last_mem, m_en, acc_a, acc_m;
  logic [RW-1:0] m_reg;
  logic [BW-1:0] m_data;
  int        m_cc;

  task automatic model_step();
    wb_entry_t e;
    bit ga, gm;
    acc_a = 0; acc_m = 0;
    if (rst) begin
      aq.delete(); mq.delete();
      m_en = 0; m_reg = '0; m_data = '0; last_mem = 1; m_cc = 0;
    end else begin
      if (PERF && aq.size() > 0 && mq.size() > 0 && m_cc < 65535) m_cc++;
      ga = aq.size() > 0 && (mq.size() == 0 || last_mem);
      gm = mq.size() > 0 && !ga;
      acc_a = bus.alu_valid && aq.size() < D;
      acc_m = bus.mem_valid && mq.size() < D;
      if (flush) begin
        aq.delete(); mq.delete(); m_en = 0; acc_a = 0; acc_m = 0;
      end else begin
        m_en = ga || gm;
        if (ga) begin e = aq.pop_front(); last_mem = 0; m_reg = e.rd; m_data = e.data; end
        if (gm) begin e = mq.pop_front(); last_mem = 1; m_reg = e.rd; m_data = e.data; end
        if (acc_a) aq.push_back('{rd: bus.alu_reg, data: bus.alu_data});
        if (acc_m) mq.push_back('{rd: bus.mem_reg, data: bus.mem_data});
      end
    end
  endtask

  function automatic logic [15:0] model_pm();
    logic [15:0] m = '0;
    foreach (aq[i]) m[aq[i].rd] = 1'b1;
    foreach (mq[i]) m[mq[i].rd] = 1'b1;
    return m;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".wb_en"},     bus.wb_en,        m_en);
    chk({tag, ".wb_reg"},    bus.wb_reg,       m_reg);
    chk({tag, ".wb_data"},   bus.wb_data,      m_data);
    chk({tag, ".alu_ready"}, bus.alu_ready,    aq.size() < D);
    chk({tag, ".mem_ready"}, bus.mem_ready,    mq.size() < D);
    chk({tag, ".pend_mask"}, bus.pend_mask,    model_pm());
    chk({tag, ".conf_cnt"},  bus.conflict_cnt, m_cc);
  endtask

  // DUT writebacks observed, in order
  wb_entry_t wblog[$];

  task automatic cyc(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(tag);
    if (bus.wb_en === 1'b1) wblog.push_back('{rd: bus.wb_reg, data: bus.wb_data});
  endtask

  task automatic idle_in();
    bus.alu_valid = 0; bus.alu_reg = '0; bus.alu_data = '0;
    bus.mem_valid = 0; bus.mem_reg = '0; bus.mem_data = '0;
  endtask

  // Sources hold valid until accepted.
  wb_entry_t srcA[$], srcM[$];
  task automatic step_src(input string tag);
    bus.alu_valid = srcA.size() > 0;
    if (srcA.size() > 0) begin bus.alu_reg = srcA[0].rd; bus.alu_data = srcA[0].data; end
    bus.mem_valid = srcM.size() > 0;
    if (srcM.size() > 0) begin bus.mem_reg = srcM[0].rd; bus.mem_data = srcM[0].data; end
    cyc(tag);
    if (acc_a) void'(srcA.pop_front());
    if (acc_m) void'(srcM.pop_front());
  endtask

  task automatic do_reset();
    idle_in(); flush = 0; rst = 1;
    cyc("rst");
    rst = 0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit av; logic [3:0] ar; logic [31:0] ad;
    bit mv; logic [3:0] mr; logic [31:0] md;
    bit fl; bit rs;
    bit e_en; logic [3:0] e_reg; logic [31:0] e_data;
    bit e_ar; bit e_mr; logic [15:0] e_pm; logic [15:0] e_cc;
  } vec_t;
  vec_t tbl[10];

  initial begin
    wb_entry_t ex[$];
    n_tests = 0; n_fail = 0;
    idle_in(); flush = 0; rst = 1;
    cyc("rst0");
    cyc("rst1");
    rst = 0;
    chk("reset.wb_en", bus.wb_en, 0);
    chk("reset.wb_reg", bus.wb_reg, 0);
    chk("reset.wb_data", bus.wb_data, 0);
    chk("reset.ready", {bus.alu_ready, bus.mem_ready}, 2'b11);
    chk("reset.pend", bus.pend_mask, 0);
    chk("reset.cc", bus.conflict_cnt, 0);

    //            av ar  ad            mv mr  md     fl rs  en reg data          ar mr pm        cc
    tbl[0] = '{1, 4'd3, 32'hDEADBEEF, 0, 4'd0, 32'h0,  0, 0,  0, 4'd0, 32'h0,        1, 1, 16'h0008, 16'd0};
    tbl[1] = '{0, 4'd0, 32'h0,        0, 4'd0, 32'h0,  0, 0,  1, 4'd3, 32'hDEADBEEF, 1, 1, 16'h0000, 16'd0};
    tbl[2] = '{0, 4'd0, 32'h0,        0, 4'd0, 32'h0,  0, 0,  0, 4'd3, 32'hDEADBEEF, 1, 1, 16'h0000, 16'd0};
    tbl[3] = '{0, 4'd0, 32'h0,        0, 4'd0, 32'h0,  0, 1,  0, 4'd0, 32'h0,        1, 1, 16'h0000, 16'd0};
    tbl[4] = '{1, 4'd1, 32'h11,       1, 4'd2, 32'h22, 0, 0,  0, 4'd0, 32'h0,        1, 1, 16'h0006, 16'd0};
    tbl[5] = '{0, 4'd0, 32'h0,        0, 4'd0, 32'h0,  0, 0,  1, 4'd1, 32'h11,       1, 1, 16'h0004, 16'd1};
    tbl[6] = '{0, 4'd0, 32'h0,        0, 4'd0, 32'h0,  0, 0,  1, 4'd2, 32'h22,       1, 1, 16'h0000, 16'd1};
    tbl[7] = '{0, 4'd0, 32'h0,        0, 4'd0, 32'h0,  0, 0,  0, 4'd2, 32'h22,       1, 1, 16'h0000, 16'd1};
    tbl[8] = '{1, 4'd7, 32'h77,       0, 4'd0, 32'h0,  1, 0,  0, 4'd2, 32'h22,       1, 1, 16'h0000, 16'd1};
    tbl[9] = '{0, 4'd0, 32'h0,        0, 4'd0, 32'h0,  0, 0,  0, 4'd2, 32'h22,       1, 1, 16'h0000, 16'd1};

    for (int i = 0; i < 10; i++) begin
      bus.alu_valid = tbl[i].av; bus.alu_reg = tbl[i].ar; bus.alu_data = tbl[i].ad;
      bus.mem_valid = tbl[i].mv; bus.mem_reg = tbl[i].mr; bus.mem_data = tbl[i].md;
      flush = tbl[i].fl; rst = tbl[i].rs;
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk($sformatf("vec%0d.wb_en", i),   bus.wb_en,   tbl[i].e_en);
      chk($sformatf("vec%0d.wb_reg", i),  bus.wb_reg,  tbl[i].e_reg);
      chk($sformatf("vec%0d.wb_data", i), bus.wb_data, tbl[i].e_data);
      chk($sformatf("vec%0d.ready", i),   {bus.alu_ready, bus.mem_ready}, {tbl[i].e_ar, tbl[i].e_mr});
      chk($sformatf("vec%0d.pend", i),    bus.pend_mask, tbl[i].e_pm);
      chk($sformatf("vec%0d.cc", i),      bus.conflict_cnt, PERF ? tbl[i].e_cc : 16'd0);
    end
    idle_in(); flush = 0; rst = 0;

    // MEM-only burst of three: retire in order
    do_reset();
    srcM = '{'{rd: 4'd5, data: 32'h1}, '{rd: 4'd6, data: 32'h2}, '{rd: 4'd7, data: 32'h3}};
    wblog.delete();
    for (int c = 0; c < 8; c++) step_src("memburst");
    ex = '{'{rd: 4'd5, data: 32'h1}, '{rd: 4'd6, data: 32'h2}, '{rd: 4'd7, data: 32'h3}};
    chk("memburst.count", wblog.size(), ex.size());
    foreach (ex[i]) if (i < wblog.size()) chk($sformatf("memburst.wb%0d", i), wblog[i], ex[i]);
    chk("memburst.src_left", srcM.size(), 0);

    // Continuous contention: MEM queue fills, grants alternate
    do_reset();
    srcA.delete(); srcM.delete(); ex.delete();
    for (int k = 0; k < 4; k++) begin
      srcA.push_back('{rd: 4'(1 + k), data: 32'hA0 + k});
      srcM.push_back('{rd: 4'(9 + k), data: 32'hB0 + k});
      ex.push_back('{rd: 4'(1 + k), data: 32'hA0 + k});
      ex.push_back('{rd: 4'(9 + k), data: 32'hB0 + k});
    end
    wblog.delete();
    step_src("cont");
    step_src("cont");
    chk("cont.mem_full_ready", bus.mem_ready, 1'b0);
    chk("cont.alu_ready", bus.alu_ready, 1'b1);
    for (int c = 0; c < 12; c++) step_src("cont");
    chk("cont.count", wblog.size(), ex.size());
    foreach (ex[i]) if (i < wblog.size()) chk($sformatf("cont.wb%0d", i), wblog[i], ex[i]);

    // Flush with queues 1+2 and a concurrent ALU push
    do_reset();
    srcA = '{'{rd: 4'd1, data: 32'h1}, '{rd: 4'd2, data: 32'h2}};
    srcM = '{'{rd: 4'd9, data: 32'h9}, '{rd: 4'd10, data: 32'hA}};
    step_src("pre_flush");
    step_src("pre_flush");
    chk("pre_flush.pend", bus.pend_mask, 16'h0604);
    srcA.delete(); srcM.delete();
    idle_in();
    bus.alu_valid = 1; bus.alu_reg = 4'd8; bus.alu_data = 32'h88;
    flush = 1;
    cyc("flush");
    flush = 0; idle_in();
    chk("flush.wb_en", bus.wb_en, 0);
    chk("flush.pend", bus.pend_mask, 0);
    chk("flush.ready", {bus.alu_ready, bus.mem_ready}, 2'b11);
    wblog.delete();
    for (int c = 0; c < 4; c++) cyc("post_flush");
    chk("post_flush.no_wb", wblog.size(), 0);

    // Reset mid-stream
    do_reset();
    srcA = '{'{rd: 4'd4, data: 32'h44}, '{rd: 4'd5, data: 32'h55}};
    srcM = '{'{rd: 4'd12, data: 32'hCC}, '{rd: 4'd13, data: 32'hDD}};
    step_src("pre_rst");
    step_src("pre_rst");
    rst = 1;
    step_src("mid_rst");
    rst = 0;
    srcA.delete(); srcM.delete(); idle_in();
    chk("mid_rst.wb_en", bus.wb_en, 0);
    chk("mid_rst.wb_reg", bus.wb_reg, 0);
    chk("mid_rst.wb_data", bus.wb_data, 0);
    chk("mid_rst.pend", bus.pend_mask, 0);
    chk("mid_rst.cc", bus.conflict_cnt, 0);
    wblog.delete();
    for (int c = 0; c < 4; c++) cyc("post_rst");
    chk("post_rst.no_wb", wblog.size(), 0);

`ifdef WB_ARBITER_PERF_EN
    do_reset();
    bus.alu_valid = 1; bus.alu_reg = 4'd1; bus.alu_data = 32'h1;
    bus.mem_valid = 1; bus.mem_reg = 4'd2; bus.mem_data = 32'h2;
    for (int c = 0; c < 70000; c++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
    chk("perf.saturate", bus.conflict_cnt, 16'hFFFF);
    flush = 1;
    cyc("perf.flush_keeps");
    flush = 0;
    chk("perf.flush_keeps_cc", bus.conflict_cnt, 16'hFFFF);
    idle_in();
`endif

    // Randomised traffic against the model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus.alu_valid = $urandom_range(0, 99) < 60;
      bus.alu_reg   = 4'($urandom);
      bus.alu_data  = $urandom;
      bus.mem_valid = $urandom_range(0, 99) < 60;
      bus.mem_reg   = 4'($urandom);
      bus.mem_data  = $urandom;
      flush         = $urandom_range(0, 99) < 3;
      rst           = $urandom_range(0, 99) < 2;
      cyc("rand");
    end
    idle_in(); flush = 0; rst = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
